// File: rtl/vga_timing.sv
// Free-running 640x480@60 Hz VGA timing generator: pixel-tick divider, h/v counters
// and registered blank/sync/frame_start flags that always describe the presented counters.
module vga_timing #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pix_tick,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hblank,
  output logic          vblank,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Five bits cover the whole legal divider range 1..16.
  localparam int unsigned DW = 5;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic          pix_tick_q, pix_tick_d;
  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          frame_start_q, frame_start_d;

  // Pixel-tick divider; the tick is registered so it lands in the cycle after div hits its last value.
  always_comb begin
    div_d      = div_q;
    pix_tick_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d = {DW{1'b0}};
    end else begin
      div_d = div_q + {{(DW-1){1'b0}}, 1'b1};
    end
    pix_tick_d = (div_d == DIV_LAST);
  end

  // Counters advance only on the edge that closes a tick cycle.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_tick_q) begin
      if (hcount_q == H_LAST) begin
        hcount_d = {CW{1'b0}};
        if (vcount_q == V_LAST) begin
          vcount_d = {CW{1'b0}};
        end else begin
          vcount_d = vcount_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end else begin
        hcount_d = hcount_q + {{(CW-1){1'b0}}, 1'b1};
        vcount_d = vcount_q;
      end
    end else begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
    end
  end

  // Status is decoded from the next counter values so it lines up with them after the edge.
  always_comb begin
    hblank_d      = (hcount_d >= H_ACT);
    vblank_d      = (vcount_d >= V_ACT);
    hsync_d       = ~SYNC_POL;
    vsync_d       = ~SYNC_POL;
    frame_start_d = pix_tick_d && (hcount_d == {CW{1'b0}}) && (vcount_d == {CW{1'b0}});
    if ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) begin
      hsync_d = SYNC_POL;
    end else begin
      hsync_d = ~SYNC_POL;
    end
    if ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) begin
      vsync_d = SYNC_POL;
    end else begin
      vsync_d = ~SYNC_POL;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= {DW{1'b0}};
      pix_tick_q    <= 1'b0;
      hcount_q      <= {CW{1'b0}};
      vcount_q      <= {CW{1'b0}};
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_tick_q    <= pix_tick_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default 640x480 instance, a CLK_DIV=1 instance and a
// shrunken active-high-sync instance small enough to run whole frames.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n = 1'b0, rst1_n = 1'b0, rst2_n = 1'b0;
  int n_cmp = 0, n_fail = 0;

  logic       tick0, hb0, vb0, hs0, vs0, fs0;
  logic [9:0] h0, v0;
  logic       tick1, hb1, vb1, hs1, vs1, fs1;
  logic [9:0] h1, v1;
  logic       tick2, hb2, vb2, hs2, vs2, fs2;
  logic [4:0] h2, v2;

  vga_timing dut0 (
    .clk(clk), .rst_n(rst0_n), .pix_tick(tick0), .hcount(h0), .vcount(v0),
    .hblank(hb0), .vblank(vb0), .hsync(hs0), .vsync(vs0), .frame_start(fs0)
  );

  vga_timing #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .pix_tick(tick1), .hcount(h1), .vcount(v1),
    .hblank(hb1), .vblank(vb1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
  );

  // H_TOTAL 16 (sync 10..12), V_TOTAL 10 (sync 7..8), sync asserted high.
  vga_timing #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
               .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1), .CW(5)) dut2 (
    .clk(clk), .rst_n(rst2_n), .pix_tick(tick2), .hcount(h2), .vcount(v2),
    .hblank(hb2), .vblank(vb2), .hsync(hs2), .vsync(vs2), .frame_start(fs2)
  );

  task automatic wait_tick0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk); #1;
      if (tick0 === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if ({tick0, h0, v0, hb0, vb0, hs0, vs0, fs0} !== {1'b0, 10'd0, 10'd0, 4'b0011, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_d0: got tick=%b h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b fs=%b want 0 0 0 0 0 1 1 0",
               tick0, h0, v0, hb0, vb0, hs0, vs0, fs0);
    end
    n_cmp++;
    if ({tick2, hs2, vs2, fs2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_d2: got tick=%b hs=%b vs=%b fs=%b want 0 0 0 0", tick2, hs2, vs2, fs2);
    end
  endtask

  task automatic test_first_ticks;
    logic exp_t;
    @(negedge clk);
    rst0_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      exp_t = (k % 4 == 3);
      n_cmp++;
      if (tick0 !== exp_t) begin
        n_fail++;
        $display("FAIL first_tick edge %0d: got %b want %b", k, tick0, exp_t);
      end
      if (k == 3 || k == 7) begin
        n_cmp++;
        if (fs0 !== (k == 3)) begin
          n_fail++;
          $display("FAIL frame_start edge %0d: got %b want %b", k, fs0, (k == 3));
        end
      end
    end
    n_cmp++;
    if (h0 !== 10'd3 || v0 !== 10'd0) begin
      n_fail++;
      $display("FAIL count_after_13: got h=%0d v=%0d want h=3 v=0", h0, v0);
    end
  endtask

  task automatic test_hline;
    bit ok;
    int prev_h = -1, prev_v = 0, step_err = 0, misc_err = 0, hs_low = 0, hb_hi = 0;
    bit wrapped = 1'b0;
    for (int n = 0; n < 805; n++) begin
      wait_tick0(ok);
      if (!ok) begin
        n_cmp++; n_fail++;
        $display("FAIL hline_tick_timeout: got no tick want tick within 8 clks");
        break;
      end
      if (prev_h >= 0) begin
        if (prev_h == 799) begin
          wrapped = 1'b1;
          n_cmp++;
          if (h0 !== 10'd0 || int'(v0) != prev_v + 1 || hb0 !== 1'b0) begin
            n_fail++;
            $display("FAIL hline_wrap: got h=%0d v=%0d hb=%b want h=0 v=%0d hb=0", h0, v0, hb0, prev_v + 1);
          end
        end else if (int'(h0) != prev_h + 1) begin
          step_err++;
        end
      end
      if (v0 == 10'd0) begin
        if (hs0 === 1'b0) hs_low++;
        if (hb0 === 1'b1) hb_hi++;
      end
      if (vb0 !== 1'b0 || vs0 !== 1'b1 || fs0 !== 1'b0) misc_err++;
      if (h0 == 10'd639 || h0 == 10'd640) begin
        n_cmp++;
        if (hb0 !== (h0 == 10'd640)) begin
          n_fail++;
          $display("FAIL hblank_edge h=%0d: got %b want %b", h0, hb0, (h0 == 10'd640));
        end
      end
      if (h0 == 10'd655 || h0 == 10'd656 || h0 == 10'd751 || h0 == 10'd752) begin
        n_cmp++;
        if (hs0 !== (h0 == 10'd655 || h0 == 10'd752)) begin
          n_fail++;
          $display("FAIL hsync_edge h=%0d: got %b want %b", h0, hs0, (h0 == 10'd655 || h0 == 10'd752));
        end
      end
      prev_h = int'(h0);
      prev_v = int'(v0);
    end
    n_cmp++;
    if (step_err != 0 || !wrapped) begin
      n_fail++;
      $display("FAIL hline_steps: got %0d bad steps wrapped=%b want 0 bad steps wrapped=1", step_err, wrapped);
    end
    n_cmp++;
    if (hs_low != 96) begin
      n_fail++;
      $display("FAIL hsync_width: got %0d ticks want 96", hs_low);
    end
    n_cmp++;
    if (hb_hi != 160) begin
      n_fail++;
      $display("FAIL hblank_width: got %0d ticks want 160", hb_hi);
    end
    n_cmp++;
    if (misc_err != 0) begin
      n_fail++;
      $display("FAIL hline_vflags: got %0d bad ticks want 0", misc_err);
    end
  endtask

  task automatic test_async_reset_d0;
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #1;
      if (h0 == 10'd300) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL d0_reach_300: got h=%0d want 300", h0);
    end
    #3;
    rst0_n = 1'b0;
    #1;
    n_cmp++;
    if ({tick0, h0, v0, hb0, vb0, hs0, vs0, fs0} !== {1'b0, 10'd0, 10'd0, 4'b0011, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_d0: got tick=%b h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b fs=%b want 0 0 0 0 0 1 1 0",
               tick0, h0, v0, hb0, vb0, hs0, vs0, fs0);
    end
    repeat (2) @(negedge clk);
    rst0_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({tick0, h0, v0, fs0} !== {1'b1, 10'd0, 10'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_d0: got tick=%b h=%0d v=%0d fs=%b want 1 0 0 1", tick0, h0, v0, fs0);
    end
  endtask

  task automatic test_clkdiv1;
    int low_ticks = 0;
    @(negedge clk);
    rst1_n = 1'b1;
    for (int k = 1; k <= 801; k++) begin
      @(posedge clk); #1;
      if (tick1 !== 1'b1) low_ticks++;
      if (k == 1) begin
        n_cmp++;
        if ({h1, v1, fs1} !== {10'd0, 10'd0, 1'b1}) begin
          n_fail++;
          $display("FAIL div1_first: got h=%0d v=%0d fs=%b want 0 0 1", h1, v1, fs1);
        end
      end
      if (k == 640 || k == 641) begin
        n_cmp++;
        if ({h1, hb1} !== {10'(k - 1), (k == 641)}) begin
          n_fail++;
          $display("FAIL div1_hblank edge %0d: got h=%0d hb=%b want h=%0d hb=%b", k, h1, hb1, k - 1, (k == 641));
        end
      end
      if (k == 656 || k == 657 || k == 752 || k == 753) begin
        n_cmp++;
        if ({h1, hs1} !== {10'(k - 1), (k == 656 || k == 753)}) begin
          n_fail++;
          $display("FAIL div1_hsync edge %0d: got h=%0d hs=%b want h=%0d hs=%b", k, h1, hs1, k - 1, (k == 656 || k == 753));
        end
      end
      if (k == 801) begin
        n_cmp++;
        if ({h1, v1, hb1, fs1} !== {10'd0, 10'd1, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL div1_line_period: got h=%0d v=%0d hb=%b fs=%b want 0 1 0 0", h1, v1, hb1, fs1);
        end
      end
    end
    n_cmp++;
    if (low_ticks != 0) begin
      n_fail++;
      $display("FAIL div1_tick_constant: got %0d low cycles want 0", low_ticks);
    end
  endtask

  task automatic test_frame_small;
    logic [15:0] got, exp;
    int n, eh, ev, vs_ticks = 0, fs_first = -1, fs_second = -1;
    bit et;
    @(negedge clk);
    rst2_n = 1'b1;
    for (int k = 1; k <= 660; k++) begin
      @(posedge clk); #1;
      n  = k / 2;
      eh = n % 16;
      ev = (n / 16) % 10;
      et = (k % 2 == 1);
      exp = {et, 5'(eh), 5'(ev), (eh >= 8), (ev >= 6), (eh >= 10 && eh <= 12),
             (ev >= 7 && ev <= 8), (et && eh == 0 && ev == 0)};
      got = {tick2, h2, v2, hb2, vb2, hs2, vs2, fs2};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL small_frame edge %0d: got %b want %b", k, got, exp);
      end
      if (k <= 320 && tick2 === 1'b1 && vs2 === 1'b1) vs_ticks++;
      if (fs2 === 1'b1) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
    end
    n_cmp++;
    if (vs_ticks != 32) begin
      n_fail++;
      $display("FAIL small_vsync_ticks: got %0d want 32", vs_ticks);
    end
    n_cmp++;
    if (fs_first != 1 || fs_second != 321) begin
      n_fail++;
      $display("FAIL small_frame_spacing: got edges %0d,%0d want 1,321", fs_first, fs_second);
    end
  endtask

  task automatic test_async_reset_small;
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (h2 == 5'd9 && v2 == 5'd7) found = 1'b1;
    end
    n_cmp++;
    if (!found || {hb2, vb2, vs2} !== 3'b111) begin
      n_fail++;
      $display("FAIL small_reach_9_7: got h=%0d v=%0d hb=%b vb=%b vs=%b want 9 7 1 1 1", h2, v2, hb2, vb2, vs2);
    end
    #3;
    rst2_n = 1'b0;
    #1;
    n_cmp++;
    if ({tick2, h2, v2, hb2, vb2, hs2, vs2, fs2} !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset_small: got %b want all zero", {tick2, h2, v2, hb2, vb2, hs2, vs2, fs2});
    end
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({tick2, h2, v2, hb2, vb2, hs2, vs2, fs2} !== {1'b1, 5'd0, 5'd0, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_small: got %b want %b", {tick2, h2, v2, hb2, vb2, hs2, vs2, fs2},
               {1'b1, 5'd0, 5'd0, 4'b0000, 1'b1});
    end
  endtask

  initial begin
    test_reset();
    test_first_ticks();
    test_hline();
    test_async_reset_d0();
    test_clkdiv1();
    test_frame_small();
    test_async_reset_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running 640x480@60 Hz VGA timing generator for the Basys board. It derives a one-cycle pixel tick from the board clock, runs horizontal and vertical pixel counters, and produces registered hblank/vblank and hsync/vsync. It sits directly upstream of rgb_visibility, which consumes hblank/vblank, and drives the VGA connector sync pins.

## Interface
- CLK_DIV, 4: board clocks per pixel (100 MHz -> 25 MHz); legal 1..16
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync pulse width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BP, 33: vertical back porch, lines
- SYNC_POL, 0: asserted sync level (0 = active-low, as 640x480 requires)
- CW, 10: counter width; H_TOTAL and V_TOTAL must each be at most 2^CW
- clk  in  1  board clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- pix_tick  out  1  one-clk pulse every CLK_DIV clks
- hcount  out  CW  current pixel column, 0..H_TOTAL-1
- vcount  out  CW  current line, 0..V_TOTAL-1
- hblank  out  1  high when hcount >= H_ACTIVE
- vblank  out  1  high when vcount >= V_ACTIVE
- hsync  out  1  horizontal sync at SYNC_POL level during the pulse
- vsync  out  1  vertical sync at SYNC_POL level during the pulse
- frame_start  out  1  one-clk pulse at pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider counter div counts 0..CLK_DIV-1 and wraps. pix_tick is registered and is high for the clk cycle following the edge on which div reaches CLK_DIV-1. With CLK_DIV=1, pix_tick is high continuously from the first edge after reset.
- On each rising clk edge with pix_tick=1:
  - hcount increments.
  - When hcount = H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - When vcount = V_TOTAL-1 at the same line end, vcount wraps to 0.
- Status outputs are registered and computed from the next counter values, so they always describe the hcount/vcount presented in the same cycle:
  - hsync asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491. vsync covers whole lines, including their horizontal blanking.
  - hblank and vblank are independent. rgb_visibility ORs them downstream.
- frame_start = pix_tick AND hcount=0 AND vcount=0. It fires on the first pix_tick after reset and then once per frame.
- No enable input. The block free-runs and never stalls.

## Timing
- Reset values (asserted and held):
  - div=0, pix_tick=0, hcount=0, vcount=0, hblank=0, vblank=0, frame_start=0
  - hsync=vsync=~SYNC_POL (deasserted; 1 at default)
- Reset is asynchronous: all outputs reach their reset values without a clock edge, including mid-line and mid-frame. Release is sampled on clk; counting restarts from (0,0).
- First pix_tick: high in the clk cycle after the (CLK_DIV-1)th rising edge after release (4th cycle at default). It then repeats every CLK_DIV cycles.
- Counters and status change only on edges where pix_tick=1. They are stable for CLK_DIV clks, and downstream samples them qualified by pix_tick.
- Periods at default:
  - Line: 800 ticks = 3200 clks.
  - Frame: 420,000 ticks = 1,680,000 clks (≈59.52 Hz at 100 MHz).
- Latency: zero from counters to status. Both update on the same edge.
- Wrap boundary (799,524) -> (0,0): hblank falls, vblank falls, and frame_start rises, all in the same cycle.

## Test plan
- Reset hold: rst_n=0 for 10 clks -> hcount=vcount=0, hblank=vblank=0, hsync=vsync=1, pix_tick=0. Deassert -> pix_tick high in cycle 4, then cycles 8, 12, …; frame_start high with the first pix_tick.
- Horizontal: step through one line -> hblank rises exactly when hcount becomes 640 and falls at wrap to 0; hsync=0 for hcount 656..751 (96 ticks); hcount 799 -> 0 with vcount +1.
- Vertical: run a full frame -> vblank high for vcount 480..524; vsync=0 for exactly 1600 ticks (lines 490–491); frame_start spacing 1,680,000 clks.
- Asynchronous reset mid-frame at (300,200), applied between clk edges -> outputs at reset values immediately, with no clk edge; after release, counting restarts and (0,0) is reached on the next pix_tick.
- CLK_DIV=1, all other parameters at defaults -> pix_tick constantly high after release; line period 800 clks; hsync and vsync positions unchanged in ticks.
- Integration with rgb_visibility -> visibility high for exactly 640x480 = 307,200 ticks per frame.
